itrx_amba3_axi_slv_wr: RTL and testbench

ITRX_AMBA3_AXI_SLV_WR -- requirements
Module: itrx_amba3_axi_slv_wr

---
 rtl/itrx_amba3_axi_slv_wr.sv | 161 ++++++++++++++++
 tb/tb_itrx_amba3_axi_slv_wr.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/itrx_amba3_axi_slv_wr.sv
// AXI3 write-channel slave front end: accepts one AW burst at a time, streams
// W beats to a simple memory port with per-beat address generation, and returns
// a single B response (OKAY or SLVERR) per burst.
module itrx_amba3_axi_slv_wr #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // write address channel
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [31:0]           awaddr,
   input  logic [3:0]            awid,
   input  logic [3:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic [1:0]            awlock,
   input  logic [3:0]            awcache,
   input  logic [2:0]            awprot,
   // write data channel
   input  logic                  wvalid,
   output logic                  wready,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  wlast,
   input  logic [3:0]            wid,
   // write response channel
   output logic                  bvalid,
   input  logic                  bready,
   output logic [3:0]            bid,
   output logic [1:0]            bresp,
   // memory side
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_be,
   input  logic                  mem_err
);

   localparam int         STRB_W     = DATA_W / 8;
   localparam logic [2:0] SIZE_MAX   = 3'($clog2(STRB_W));
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, DATA, RESP, ERRDRAIN} state_t;

   state_t      state;
   logic [3:0]  id_q;
   logic [3:0]  len_q;
   logic [3:0]  beat_q;
   logic [31:0] addr_q;
   logic [2:0]  size_q;
   logic [1:0]  burst_q;
   logic        err_q;

   logic [31:0] step;
   logic [31:0] aligned;
   logic [31:0] incr_addr;
   logic [31:0] wrap_mask;
   logic [31:0] next_addr;
   logic        aw_illegal;
   logic        beat_done;
   logic        beat_err;
   logic        last_beat;

   // Lock, cache and protection attributes do not affect this slave (no exclusive monitor).
   logic unused_attrs;
   assign unused_attrs = ^{awlock, awcache, awprot};

   // Address of the following beat; the first beat keeps awaddr as given, later beats are size-aligned.
   always_comb begin
      step      = 32'd1 << size_q;
      aligned   = addr_q & ~(step - 32'd1);
      incr_addr = aligned + step;
      wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
      next_addr = incr_addr;
      case (burst_q)
         BURST_FIXED: next_addr = addr_q;
         BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
         default:     next_addr = incr_addr;
      endcase
   end

   // Burst legality and per-beat error detection.
   always_comb begin
      aw_illegal = (awsize > SIZE_MAX) || (awburst == BURST_RSVD) ||
                   ((awburst == BURST_WRAP) &&
                    !((awlen == 4'd1) || (awlen == 4'd3) || (awlen == 4'd7) || (awlen == 4'd15)));
      beat_done  = wvalid && wready;
      last_beat  = wlast || (beat_q == len_q);
      beat_err   = (mem_we && mem_err) || (wlast != (beat_q == len_q)) || (wid != id_q);
   end

   assign mem_we    = (state == DATA) && wvalid;
   assign mem_addr  = addr_q;
   assign mem_wdata = (state == DATA) ? wdata : '0;
   assign mem_be    = (state == DATA) ? wstrb : '0;

   // Burst controller: state, latched AW fields and registered handshake/response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         awready <= 1'b1;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bid     <= 4'd0;
         bresp   <= RESP_OKAY;
         id_q    <= 4'd0;
         len_q   <= 4'd0;
         beat_q  <= 4'd0;
         addr_q  <= 32'd0;
         size_q  <= 3'd0;
         burst_q <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (awvalid) begin
                  id_q    <= awid;
                  addr_q  <= awaddr;
                  len_q   <= awlen;
                  size_q  <= awsize;
                  burst_q <= awburst;
                  beat_q  <= 4'd0;
                  err_q   <= aw_illegal;
                  awready <= 1'b0;
                  wready  <= 1'b1;
                  state   <= aw_illegal ? ERRDRAIN : DATA;
               end
            end
            DATA, ERRDRAIN: begin
               if (beat_done) begin
                  if (last_beat) begin
                     state  <= RESP;
                     wready <= 1'b0;
                     bvalid <= 1'b1;
                     bid    <= id_q;
                     bresp  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                  end else begin
                     beat_q <= beat_q + 4'd1;
                     addr_q <= next_addr;
                     err_q  <= err_q || beat_err;
                  end
               end
            end
            RESP: begin
               if (bready) begin
                  state   <= IDLE;
                  bvalid  <= 1'b0;
                  awready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_itrx_amba3_axi_slv_wr.sv
// Directed self-checking bench for the AXI3 write slave: burst types, error
// cases, response back-pressure and mid-burst reset.
module tb_itrx_amba3_axi_slv_wr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [3:0]  awid, awlen, awcache;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, awlock;
   logic        wvalid, wready, wlast;
   logic [31:0] wdata;
   logic [3:0]  wstrb, wid;
   logic        bvalid, bready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        mem_we, mem_err;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int tests  = 0;
   int failed = 0;

   itrx_amba3_axi_slv_wr #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
      .awcache(awcache), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .wlast(wlast), .wid(wid),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // Present an AW request and hold it until the handshake edge.
   task automatic send_aw(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n;
      @(negedge clk);
      awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
      n = 0;
      while (awready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (awready !== 1'b1) begin
         failed++;
         $display("[TB] FAIL aw_accept: awready=%b required 1", awready);
      end
      @(posedge clk);
      #1 awvalid = 1'b0;
   endtask

   // Present one W beat and check the memory port in the same cycle.
   task automatic send_beat(input string name, input logic [31:0] data, input logic [3:0] strb,
                            input logic last, input logic [3:0] id, input logic err,
                            input logic exp_we, input logic [31:0] exp_addr);
      int n;
      @(negedge clk);
      wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last; wid = id; mem_err = err;
      n = 0;
      while (wready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      #1;
      tests++;
      if (wready !== 1'b1) begin
         failed++;
         $display("[TB] FAIL %s wready: got %b required 1", name, wready);
      end
      tests++;
      if (mem_we !== exp_we) begin
         failed++;
         $display("[TB] FAIL %s mem_we: got %b required %b", name, mem_we, exp_we);
      end
      if (exp_we) begin
         tests++;
         if (mem_addr !== exp_addr || mem_wdata !== data || mem_be !== strb) begin
            failed++;
            $display("[TB] FAIL %s mem: addr=%h data=%h be=%h required %h %h %h",
                     name, mem_addr, mem_wdata, mem_be, exp_addr, data, strb);
         end
      end
      @(posedge clk);
      #1 wvalid = 1'b0; wlast = 1'b0; mem_err = 1'b0;
   endtask

   // Wait for the B response, optionally stall it, then complete the handshake.
   task automatic check_b(input string name, input logic [3:0] exp_id, input logic [1:0] exp_resp,
                          input int hold);
      int n;
      @(negedge clk);
      n = 0;
      while (bvalid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (bvalid !== 1'b1 || bid !== exp_id || bresp !== exp_resp || wready !== 1'b0) begin
         failed++;
         $display("[TB] FAIL %s resp: bvalid=%b bid=%h bresp=%b wready=%b required 1 %h %b 0",
                  name, bvalid, bid, bresp, wready, exp_id, exp_resp);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         tests++;
         if (bvalid !== 1'b1 || bid !== exp_id || bresp !== exp_resp || awready !== 1'b0) begin
            failed++;
            $display("[TB] FAIL %s hold%0d: bvalid=%b bid=%h bresp=%b awready=%b required 1 %h %b 0",
                     name, i, bvalid, bid, bresp, awready, exp_id, exp_resp);
         end
      end
      bready = 1'b1;
      @(posedge clk);
      #1 bready = 1'b0;
      tests++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         failed++;
         $display("[TB] FAIL %s done: bvalid=%b awready=%b required 0 1", name, bvalid, awready);
      end
   endtask

   // Reset values on every observable output.
   task automatic test_reset();
      rst_n = 1'b0;
      awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
      awlock = 0; awcache = 0; awprot = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; wid = 0; bready = 0; mem_err = 0;
      #12;
      tests++;
      if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 4'd0 ||
          bresp !== 2'b00 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin
         failed++;
         $display("[TB] FAIL reset: aw=%b w=%b b=%b bid=%h bresp=%b we=%b addr=%h required 1 0 0 0 00 0 0",
                  awready, wready, bvalid, bid, bresp, mem_we, mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wvalid = 1'b1;
      #1;
      tests++;
      if (wready !== 1'b0 || mem_we !== 1'b0) begin
         failed++;
         $display("[TB] FAIL idle_no_w: wready=%b mem_we=%b required 0 0", wready, mem_we);
      end
      wvalid = 1'b0;
   endtask

   // INCR burst of four words.
   task automatic test_incr();
      send_aw(32'h100, 4'd5, 4'd3, 3'd2, 2'b01);
      send_beat("incr0", 32'hA0, 4'hF, 0, 4'd5, 0, 1, 32'h100);
      send_beat("incr1", 32'hA1, 4'h3, 0, 4'd5, 0, 1, 32'h104);
      send_beat("incr2", 32'hA2, 4'hC, 0, 4'd5, 0, 1, 32'h108);
      send_beat("incr3", 32'hA3, 4'hF, 1, 4'd5, 0, 1, 32'h10C);
      check_b("incr", 4'd5, 2'b00, 0);
   endtask

   // WRAP burst crossing its 16-byte boundary.
   task automatic test_wrap();
      send_aw(32'h38, 4'd9, 4'd3, 3'd2, 2'b10);
      send_beat("wrap0", 32'hB0, 4'hF, 0, 4'd9, 0, 1, 32'h38);
      send_beat("wrap1", 32'hB1, 4'hF, 0, 4'd9, 0, 1, 32'h3C);
      send_beat("wrap2", 32'hB2, 4'hF, 0, 4'd9, 0, 1, 32'h30);
      send_beat("wrap3", 32'hB3, 4'hF, 1, 4'd9, 0, 1, 32'h34);
      check_b("wrap", 4'd9, 2'b00, 0);
   endtask

   // FIXED burst, then an unaligned INCR start issued back to back.
   task automatic test_back_to_back();
      send_aw(32'h20, 4'd2, 4'd2, 3'd2, 2'b00);
      send_beat("fix0", 32'hC0, 4'hF, 0, 4'd2, 0, 1, 32'h20);
      send_beat("fix1", 32'hC1, 4'hF, 0, 4'd2, 0, 1, 32'h20);
      send_beat("fix2", 32'hC2, 4'hF, 1, 4'd2, 0, 1, 32'h20);
      check_b("fixed", 4'd2, 2'b00, 0);
      send_aw(32'h102, 4'd3, 4'd1, 3'd2, 2'b01);
      send_beat("unal0", 32'hD0, 4'hC, 0, 4'd3, 0, 1, 32'h102);
      send_beat("unal1", 32'hD1, 4'hF, 1, 4'd3, 0, 1, 32'h104);
      check_b("unaligned", 4'd3, 2'b00, 0);
   endtask

   // Illegal AW: beats drained without memory writes, SLVERR returned.
   task automatic test_illegal();
      send_aw(32'h40, 4'd6, 4'd1, 3'd2, 2'b11);
      send_beat("rsvd0", 32'hE0, 4'hF, 0, 4'd6, 0, 0, 32'h0);
      send_beat("rsvd1", 32'hE1, 4'hF, 1, 4'd6, 0, 0, 32'h0);
      check_b("rsvd_burst", 4'd6, 2'b10, 0);
      send_aw(32'h40, 4'd7, 4'd2, 3'd2, 2'b10);
      send_beat("wl2_0", 32'hE2, 4'hF, 0, 4'd7, 0, 0, 32'h0);
      send_beat("wl2_1", 32'hE3, 4'hF, 0, 4'd7, 0, 0, 32'h0);
      send_beat("wl2_2", 32'hE4, 4'hF, 1, 4'd7, 0, 0, 32'h0);
      check_b("wrap_len2", 4'd7, 2'b10, 0);
      send_aw(32'h40, 4'd8, 4'd0, 3'd3, 2'b01);
      send_beat("size8", 32'hE5, 4'hF, 1, 4'd8, 0, 0, 32'h0);
      check_b("oversize", 4'd8, 2'b10, 0);
   endtask

   // Protocol and memory errors, plus B back-pressure.
   task automatic test_errors();
      send_aw(32'h200, 4'd1, 4'd3, 3'd2, 2'b01);
      send_beat("early0", 32'hF0, 4'hF, 0, 4'd1, 0, 1, 32'h200);
      send_beat("early1", 32'hF1, 4'hF, 1, 4'd1, 0, 1, 32'h204);
      check_b("early_last", 4'd1, 2'b10, 0);
      send_aw(32'h300, 4'd4, 4'd3, 3'd2, 2'b01);
      send_beat("merr0", 32'h10, 4'hF, 0, 4'd4, 0, 1, 32'h300);
      send_beat("merr1", 32'h11, 4'hF, 0, 4'd4, 0, 1, 32'h304);
      send_beat("merr2", 32'h12, 4'hF, 0, 4'd4, 1, 1, 32'h308);
      send_beat("merr3", 32'h13, 4'hF, 1, 4'd4, 0, 1, 32'h30C);
      check_b("mem_err", 4'd4, 2'b10, 5);
      send_aw(32'h400, 4'd10, 4'd0, 3'd2, 2'b01);
      send_beat("widbad", 32'h20, 4'hF, 1, 4'd11, 0, 1, 32'h400);
      check_b("wid_mismatch", 4'd10, 2'b10, 0);
   endtask

   // Reset mid-burst: outputs return to reset values at once, no response, next burst normal.
   task automatic test_reset_mid();
      send_aw(32'h500, 4'd12, 4'd3, 3'd2, 2'b01);
      send_beat("rst0", 32'h30, 4'hF, 0, 4'd12, 0, 1, 32'h500);
      send_beat("rst1", 32'h31, 4'hF, 0, 4'd12, 0, 1, 32'h504);
      @(negedge clk);
      wvalid = 1'b1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || mem_we !== 1'b0 ||
          mem_addr !== 32'd0 || bresp !== 2'b00 || bid !== 4'd0) begin
         failed++;
         $display("[TB] FAIL reset_mid: aw=%b w=%b b=%b we=%b addr=%h bresp=%b bid=%h required 1 0 0 0 0 00 0",
                  awready, wready, bvalid, mem_we, mem_addr, bresp, bid);
      end
      @(negedge clk);
      wvalid = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (bvalid !== 1'b0) begin
         failed++;
         $display("[TB] FAIL reset_no_b: bvalid=%b required 0", bvalid);
      end
      send_aw(32'h600, 4'd13, 4'd1, 3'd2, 2'b01);
      send_beat("post0", 32'h40, 4'hF, 0, 4'd13, 0, 1, 32'h600);
      send_beat("post1", 32'h41, 4'hF, 1, 4'd13, 0, 1, 32'h604);
      check_b("post_reset", 4'd13, 2'b00, 0);
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_back_to_back();
      test_illegal();
      test_errors();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
